// File: rtl/kyber_pkg.sv
// kyber_pkg: shared types and constants for the Kyber decode sequencer.
//   state_e        : sequencer states
//   N_COEFF_WORDS  : coefficient words produced per polynomial
//   L_MAX, K_MAX   : largest legal bits-per-coefficient and polynomial count
//   nwords(l)      : packed 64-bit input words per polynomial (32*l bytes)
package kyber_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int N_COEFF_WORDS = 64;
  localparam int L_MAX         = 12;
  localparam int K_MAX         = 4;

  // 256 coefficients * l bits / 64 bits per word = 4*l words.
  function automatic logic [5:0] nwords(input logic [3:0] l);
    return {l, 2'b00};
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry FIFO absorbing the one-cycle source read latency.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : drop all entries
//   push_i/data_i : write one word
//   pop_i         : consume the head word (caller ensures valid_o)
//   data_o        : head word, stable until popped
//   valid_o       : FIFO not empty
//   count_o       : number of stored words (0..2)
module skid_fifo2 #(
  parameter int DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // The issue rule upstream keeps the FIFO from overflowing; the guard
  // only stops a misbehaving producer from corrupting the head entry.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: sequencer for the Kyber decode datapath.
// Streams k polynomials of packed l-bit coefficients from the source word
// memory into decode, and writes the returned coefficient words into the
// destination memory.
//   i_clk, i_rstn          : clock, asynchronous active-low reset
//   i_start, i_l, i_k      : command strobe (sampled in IDLE), l (1..12), k (1..4)
//   i_src_base, i_dst_base : first source / destination word address
//   o_busy, o_done, o_err  : status (done and err are 1-cycle pulses)
//   o_src_ren/raddr        : source read port, i_src_rdata valid one cycle later
//   o_dec_ibytes*, o_dec_l : input stream and l to decode
//   i_dec_coeffs*, i_dec_done : coefficient stream and end-of-polynomial from decode
//   o_dst_wen/waddr/wdata  : destination write port
//
// Handshake: a word moves to decode in any cycle where o_dec_ibytes_valid and
// i_dec_ibytes_ready are both high; o_dec_ibytes and its valid are held
// unchanged while valid is high and ready is low.
module decode_ctrl
  import kyber_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DW     = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [3:0]        i_l,
  input  logic [2:0]        i_k,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_src_ren,
  output logic [ADDR_W-1:0] o_src_raddr,
  input  logic [DW-1:0]     i_src_rdata,
  output logic [DW-1:0]     o_dec_ibytes,
  output logic              o_dec_ibytes_valid,
  input  logic              i_dec_ibytes_ready,
  output logic [3:0]        o_dec_l,
  input  logic [DW-1:0]     i_dec_coeffs,
  input  logic              i_dec_coeffs_valid,
  input  logic              i_dec_done,
  output logic              o_dst_wen,
  output logic [ADDR_W-1:0] o_dst_waddr,
  output logic [DW-1:0]     o_dst_wdata
);

  state_e            state_q, state_d;
  logic [3:0]        l_q, l_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [1:0]        poly_idx_q, poly_idx_d;
  logic [5:0]        issued_q, issued_d;
  logic [6:0]        coeff_cnt_q, coeff_cnt_d;
  logic              done_seen_q, done_seen_d;
  logic              inflight_q, inflight_d;
  logic              err_q, err_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [5:0]        nw;
  logic [7:0]        poly_off;
  logic [2:0]        occ;
  logic              src_ren;
  logic              cmd_legal;
  logic              coeff_err;
  logic              fifo_pop;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [DW-1:0]     fifo_data;

  assign nw        = nwords(l_q);
  assign poly_off  = 8'(poly_idx_q) * 8'(nw);
  assign fifo_pop  = fifo_valid && i_dec_ibytes_ready;
  // Occupancy after this cycle's pop, counting the read still in flight.
  // Including the pop lets a new read issue every cycle while decode keeps
  // up, yet the two entries can never be exceeded.
  assign occ       = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
  assign src_ren   = (state_q == S_FETCH) && (issued_q < nw) && (occ < 3'd2);
  assign cmd_legal = (i_l != 4'd0) && (i_l <= 4'(L_MAX)) &&
                     (i_k != 3'd0) && (i_k <= 3'(K_MAX));
  assign coeff_err = (state_q != S_IDLE) && i_dec_coeffs_valid &&
                     (coeff_cnt_q == 7'(N_COEFF_WORDS));

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    k_d         = k_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    poly_idx_d  = poly_idx_q;
    issued_d    = issued_q;
    coeff_cnt_d = coeff_cnt_q;
    done_seen_d = done_seen_q;
    inflight_d  = src_ren;
    err_d       = 1'b0;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    if (src_ren) begin
      issued_d = issued_q + 6'd1;
    end

    // Coefficient path runs in every active state; decode may finish a
    // polynomial while its last input words are still being fetched.
    if (state_q != S_IDLE) begin
      if (i_dec_done) begin
        done_seen_d = 1'b1;
      end
      if (i_dec_coeffs_valid && !coeff_err) begin
        wen_d       = 1'b1;
        waddr_d     = dst_base_q + ADDR_W'({poly_idx_q, 6'd0}) + ADDR_W'(coeff_cnt_q);
        wdata_d     = i_dec_coeffs;
        coeff_cnt_d = coeff_cnt_q + 7'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (cmd_legal) begin
            l_d         = i_l;
            k_d         = i_k;
            src_base_d  = i_src_base;
            dst_base_d  = i_dst_base;
            poly_idx_d  = 2'd0;
            issued_d    = 6'd0;
            coeff_cnt_d = 7'd0;
            done_seen_d = 1'b0;
            state_d     = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (issued_q == nw) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!fifo_valid && !inflight_q && done_seen_q &&
            (coeff_cnt_q == 7'(N_COEFF_WORDS))) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        issued_d    = 6'd0;
        coeff_cnt_d = 7'd0;
        done_seen_d = 1'b0;
        poly_idx_d  = poly_idx_q + 2'd1;
        if (({1'b0, poly_idx_q} + 3'd1) == k_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Surplus coefficient: abandon the command; the outstanding read (if
    // any) is forgotten so its data is never pushed.
    if (coeff_err) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      l_q         <= 4'd0;
      k_q         <= 3'd0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      poly_idx_q  <= 2'd0;
      issued_q    <= 6'd0;
      coeff_cnt_q <= 7'd0;
      done_seen_q <= 1'b0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      k_q         <= k_d;
      src_base_q  <= src_base_d;
      dst_base_q  <= dst_base_d;
      poly_idx_q  <= poly_idx_d;
      issued_q    <= issued_d;
      coeff_cnt_q <= coeff_cnt_d;
      done_seen_q <= done_seen_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  skid_fifo2 #(.DW(DW)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .flush_i (coeff_err),
    .push_i  (inflight_q),
    .data_i  (i_src_rdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign o_busy             = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                              (state_q == S_NEXT);
  assign o_done             = (state_q == S_DONE);
  assign o_err              = err_q;
  assign o_src_ren          = src_ren;
  assign o_src_raddr        = src_ren ? (src_base_q + ADDR_W'(poly_off) + ADDR_W'(issued_q))
                                      : '0;
  assign o_dec_ibytes       = fifo_data;
  assign o_dec_ibytes_valid = fifo_valid;
  assign o_dec_l            = o_busy ? l_q : 4'd0;
  assign o_dst_wen          = wen_q;
  assign o_dst_waddr        = waddr_q;
  assign o_dst_wdata        = wdata_q;

endmodule
